// File: rtl/otter_pkg.sv
// Shared types for the data-memory load/store port: access sizes, FSM states,
// and store lane helpers.
package otter_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {IDLE, RD, LD, WR, RSP} mem_port_state_t;

  // Byte-enable mask for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_mask(mem_size_t sz, logic [1:0] off);
    case (sz)
      MEM_BYTE: store_mask = 4'b0001 << off;
      MEM_HALF: store_mask = 4'b0011 << {off[1], 1'b0};
      MEM_WORD: store_mask = 4'b1111;
      default:  store_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(mem_size_t sz, logic [31:0] wd);
    case (sz)
      MEM_BYTE: store_data = {4{wd[7:0]}};
      MEM_HALF: store_data = {2{wd[15:0]}};
      default:  store_data = wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_if.sv
// CPU-side request/response bundle between the core control unit and mem_port.
interface mem_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a RAM word and sign- or zero-extends it.
module load_align
  import otter_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  mem_size_t   i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [3:0][7:0] w_lanes;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;

  assign w_lanes = i_rdata;

  always_comb begin
    w_byte = w_lanes[i_offset];
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_size)
      MEM_BYTE: o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      MEM_HALF: o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default:  o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_port.sv
// Load/store front-end for the data block RAM: one request at a time, byte/half/word.
// Define MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them.
module mem_port
  import otter_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_if.slave             bus,
  output logic                  ram_rd_n,
  output logic [3:0]            ram_we,
  output logic [ADDR_WIDTH-3:0] ram_addr,
  output logic [31:0]           ram_wdata,
  input  logic [31:0]           ram_rdata
);

  mem_port_state_t       r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  mem_size_t             r_size;
  logic                  r_uns;
  logic                  r_err;
  logic [3:0]            r_mask;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;

  mem_size_t             w_size;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_fault;
  logic                  w_accept;
  logic [31:0]           w_ld;
  logic                  w_unused_addr;

  assign w_size        = mem_size_t'(bus.req_size);
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_unused_addr = ^bus.req_addr[31:ADDR_WIDTH];

  always_comb begin
    w_addr  = bus.req_addr[ADDR_WIDTH-1:0];
    w_fault = (w_size == MEM_RSVD);
`ifdef MISALIGN_TRAP_EN
    if (w_size == MEM_HALF && w_addr[0])          w_fault = 1'b1;
    if (w_size == MEM_WORD && w_addr[1:0] != '0)  w_fault = 1'b1;
`else
    if (w_size == MEM_HALF) w_addr[0]   = 1'b0;
    if (w_size == MEM_WORD) w_addr[1:0] = 2'b00;
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_fault ? RSP : (bus.req_we ? WR : RD);
      RD:      w_next = LD;
      LD:      w_next = RSP;
      WR:      w_next = RSP;
      RSP:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_size  <= MEM_BYTE;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_mask  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= w_addr;
        r_size  <= w_size;
        r_uns   <= bus.req_unsigned;
        r_err   <= w_fault;
        // A faulted store keeps a zero mask so nothing can reach the RAM.
        r_mask  <= w_fault ? 4'b0000 : store_mask(w_size, w_addr[1:0]);
        r_wdata <= store_data(w_size, bus.req_wdata);
        r_rdata <= '0;
      end
      if (r_state == LD) r_rdata <= w_ld;
    end
  end

  load_align u_align (
    .i_rdata    (ram_rdata),
    .i_offset   (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_ld)
  );

  assign bus.req_ready = (r_state == IDLE) && !rst;
  assign bus.rsp_valid = (r_state == RSP) && !rst;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  assign ram_rd_n  = !((r_state == RD) && !rst);
  assign ram_we    = ((r_state == WR) && !rst) ? r_mask : 4'b0000;
  assign ram_addr  = r_addr[ADDR_WIDTH-1:2];
  assign ram_wdata = r_wdata;

endmodule

// File: tb/tb_mem_port.sv
// Self-checking bench for mem_port: directed cases plus randomized accesses
// checked against a byte-array reference memory.
module tb_mem_port;

  localparam int AW = 15;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_rd_n;
  logic [3:0]    ram_we;
  logic [AW-3:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  logic          pl_en;
  logic [AW-3:0] pl_addr;
  logic [31:0]   pl_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  rmem [0:255];
  logic [31:0] last_rdata;
  logic        last_err;
  logic [3:0]  last_we;
  logic [31:0] last_wd;

  always #5 clk = ~clk;

  mem_port_if bus();

  mem_port #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_rd_n  (ram_rd_n),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Block RAM: registered read, byte-enabled write, plus a preload port.
  logic [31:0] ram [0:8191];
  always @(posedge clk) begin
    logic [31:0] nw;
    nw = ram[ram_addr];
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) nw[b*8 +: 8] = ram_wdata[b*8 +: 8];
    if (!ram_rd_n) ram_rdata <= ram[ram_addr];
    if (|ram_we) ram[ram_addr] <= nw;
    if (pl_en) ram[pl_addr] <= pl_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wd);
    logic [14:0] ea;
    logic        flt;
    int          nb, lat, n, rd_cnt;
    logic [3:0]  xm, we_seen;
    logic [31:0] xr, xd, wd_seen;
    ea  = addr[14:0];
    flt = (sz == 2'b11) || (TRAP && ((sz == 2'b01 && ea[0]) || (sz == 2'b10 && ea[1:0] != 2'b00)));
    if (!TRAP && sz == 2'b01) ea[0] = 1'b0;
    if (!TRAP && sz == 2'b10) ea[1:0] = 2'b00;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    xr = '0; xm = '0; xd = '0;
    if (!flt && !we) begin
      for (int k = 0; k < nb; k++) xr |= 32'(rmem[(int'(ea) + k) & 255]) << (8 * k);
      if (sz == 2'b00 && !uns) xr = {{24{xr[7]}}, xr[7:0]};
      if (sz == 2'b01 && !uns) xr = {{16{xr[15]}}, xr[15:0]};
    end
    if (!flt && we) begin
      for (int k = 0; k < nb; k++) xm[(int'(ea) + k) % 4] = 1'b1;
      xd = (sz == 2'b00) ? {4{wd[7:0]}} : (sz == 2'b01) ? {2{wd[15:0]}} : wd;
    end
    lat = flt ? 1 : (we ? 2 : 3);

    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wd;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bus.req_addr = $urandom; bus.req_wdata = $urandom;
    n = 0; rd_cnt = 0; we_seen = '0; wd_seen = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n++;
      if (!ram_rd_n) rd_cnt++;
      if (ram_we != 4'b0000) begin we_seen = ram_we; wd_seen = ram_wdata; end
      if (bus.rsp_valid) break;
    end
    check("rsp_latency", 32'(bus.rsp_valid ? n : 99), 32'(lat));
    check("rsp_err", 32'(bus.rsp_err), 32'(flt));
    check("rsp_rdata", bus.rsp_rdata, xr);
    check("rd_strobes", 32'(rd_cnt), 32'((!flt && !we) ? 1 : 0));
    check("ram_we", 32'(we_seen), 32'(xm));
    if (!flt && we) check("ram_wdata", wd_seen, xd);
    last_rdata = bus.rsp_rdata; last_err = bus.rsp_err;
    last_we = we_seen; last_wd = wd_seen;
    if (!flt && we)
      for (int k = 0; k < nb; k++) rmem[(int'(ea) + k) & 255] = wd[8*k +: 8];
    @(negedge clk);
    check("rsp_pulse_end", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] a;
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (i == 4) w = 32'h80017F80;
      if (i == 8) w = 32'h11223344;
      @(negedge clk);
      pl_en = 1'b1; pl_addr = (AW-2)'(i); pl_data = w;
      for (int k = 0; k < 4; k++) rmem[i*4 + k] = w[8*k +: 8];
    end
    @(negedge clk);
    pl_en = 1'b0;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_ram_rd_n", 32'(ram_rd_n), 32'd1);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    rst = 1'b0;

    run(1'b0, 2'b00, 1'b0, 32'h10, 0); check("lb_10", last_rdata, 32'hFFFFFF80);
    run(1'b0, 2'b00, 1'b1, 32'h13, 0); check("lbu_13", last_rdata, 32'h00000080);
    run(1'b0, 2'b01, 1'b0, 32'h12, 0); check("lh_12", last_rdata, 32'hFFFF8001);
    run(1'b0, 2'b01, 1'b1, 32'h10, 0); check("lhu_10", last_rdata, 32'h00007F80);

    run(1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AB);
    check("sb_we", 32'(last_we), 32'b0010);
    check("sb_wdata", last_wd, 32'hABABABAB);
    run(1'b0, 2'b10, 1'b0, 32'h20, 0); check("lw_20_sb", last_rdata, 32'h1122AB44);
    run(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF);
    check("sh_we", 32'(last_we), 32'b1100);
    check("sh_wdata", last_wd, 32'hBEEFBEEF);
    run(1'b1, 2'b10, 1'b0, 32'h24, 32'hDEADBEEF);
    check("sw_we", 32'(last_we), 32'b1111);
    run(1'b0, 2'b10, 1'b0, 32'h20, 0); check("lw_20_sh", last_rdata, 32'hBEEFAB44);
    run(1'b0, 2'b10, 1'b0, 32'h24, 0); check("lw_24", last_rdata, 32'hDEADBEEF);

    run(1'b0, 2'b10, 1'b0, 32'h06, 0);
    check("lw_06_err", 32'(last_err), 32'(TRAP));
    run(1'b0, 2'b11, 1'b0, 32'h08, 0); check("rsvd_ld_err", 32'(last_err), 32'd1);
    run(1'b1, 2'b11, 1'b0, 32'h08, 32'h5A5A5A5A); check("rsvd_st_err", 32'(last_err), 32'd1);

    // Reset landing on the WR cycle must squash both the write and the response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'b10;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h30; bus.req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 bus.req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rstwr_ram_we", 32'(ram_we), 32'd0);
    check("rstwr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstwr_ready", 32'(bus.req_ready), 32'd1);
    check("rstwr_no_rsp", 32'(bus.rsp_valid), 32'd0);
    run(1'b0, 2'b10, 1'b0, 32'h30, 0);

    for (int i = 0; i < 300; i++) begin
      a = ($urandom & 32'hFFFF8000) | 32'($urandom_range(0, 255));
      run(1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
          1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
